imem_fetch_unit: RTL and testbench
==================================

Name: imem_fetch_unit

Overview:
- Requester side of the instruction-memory port: drives `address_o`, `DATA_o`, `IWR_EN_o` and `IR_EN_o`, and consumes `DATA_i`.
- Two phases:
  - LOAD: streams a program image into instruction memory as sequential writes.
  - FETCH: issues sequential reads and buffers the returned words in a small prefetch FIFO.
- Delivers instructions to the decoder over a valid/ready handshake and supports PC redirect (branch/jump flush).

Parameters:
- RESET_PC, 32'h0000_0000, first load address and first fetch address.
- FIFO_DEPTH, 2, prefetch entries; power of two, ≥2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- load_valid_i  in  1  loader word valid.
- load_data_i  in  32  loader instruction word.
- load_ready_o  out  1  unit accepts loader words (LOAD state).
- load_done_i  in  1  image complete; enter FETCH.
- redirect_i  in  1  flush and restart fetch.
- redirect_pc_i  in  32  new fetch PC.
- instr_valid_o  out  1  FIFO head valid.
- instr_o  out  32  FIFO head instruction.
- instr_pc_o  out  32  PC of FIFO head.
- instr_ready_i  in  1  decoder accepts head.
- address_o  out  32  memory byte address.
- DATA_o  out  32  memory write data.
- DATA_i  in  32  memory read data, valid the cycle after `IR_EN_o`.
- IWR_EN_o  out  1  memory write enable.
- IR_EN_o  out  1  memory read enable.

Behaviour:
- Clock, reset and memory timing:
  - Single clock `clk_i`; `rst_i` is synchronous and active-high.
  - Memory read latency is fixed at 1 cycle.
- Reset:
  - State = LOAD, load_addr = RESET_PC, fetch_pc = RESET_PC, FIFO empty, in-flight flag clear.
  - Outputs while `rst_i` is high: `load_ready_o` = 0, `instr_valid_o` = 0, `instr_o` = 0, `instr_pc_o` = 0, `IWR_EN_o` = 0, `IR_EN_o` = 0, `address_o` = 0, `DATA_o` = 0.
  - Reset asserted mid-operation aborts everything in the next cycle; the in-flight read is discarded.
- LOAD state:
  - `load_ready_o` = 1; `IR_EN_o` = 0.
  - `IWR_EN_o` = `load_valid_i`, `address_o` = load_addr, `DATA_o` = `load_data_i` (combinational).
  - Each accepted word advances load_addr by 4; the address wraps mod 2^32.
  - On `load_done_i`, go to FETCH. If `load_valid_i` is also high that cycle, the word is written first.
  - `redirect_i` is ignored in LOAD.
- FETCH state:
  - `load_ready_o` = 0, `IWR_EN_o` = 0, `DATA_o` = 0.
  - Issue a read when (fifo_count + inflight − pop) < FIFO_DEPTH and no redirect is pending.
    - Issue drives `IR_EN_o` = 1 and `address_o` = fetch_pc.
    - fetch_pc += 4 (wraps); inflight is set with the issued PC.
  - Response: the cycle after an issue, `DATA_i` and its PC are pushed into the FIFO.
  - First instruction reaches `instr_valid_o` 2 cycles after entering FETCH.
  - Steady state with `instr_ready_i` held high is 1 instruction per cycle.
- Decoder handshake:
  - Pop when `instr_valid_o` && `instr_ready_i`.
  - `instr_o`/`instr_pc_o` hold stable while valid and not accepted.
  - Push and pop in the same cycle are allowed, including when the FIFO is full.
- Redirect (FETCH only):
  - Flushes the FIFO and discards the in-flight response.
  - fetch_pc ← {redirect_pc_i[31:2], 2'b00}.
  - `instr_valid_o` = 0 in the next cycle.
  - No read is issued in the redirect cycle; the first read at the new PC is issued the following cycle.
  - Redirect has priority over a simultaneous pop (the pop is treated as accepted) and over a push.
- Invariant: the FIFO never overflows; the issue throttle counts in-flight reads.

Optional Feature:
- Macro IFU_PERF_CNT_EN.
- Defined: adds outputs `fetch_cnt_o` [31:0] and `stall_cnt_o` [31:0].
  - `fetch_cnt_o` counts accepted instructions (pop).
  - `stall_cnt_o` counts FETCH cycles with `instr_valid_o` = 0.
  - Both are reset to 0, wrap mod 2^32, and are unaffected by redirect.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Load: rst_i 2 cycles, then 4 words 0x00000013, 0x00100093, 0x00200113, 0x00308193 with load_valid_i held, then load_done_i → IWR_EN_o pulses at address_o 0x0, 0x4, 0x8, 0xC with matching DATA_o; IR_EN_o never high in LOAD.
- Streaming fetch: after load, instr_ready_i = 1 → IR_EN_o at 0x0, 0x4, 0x8… on consecutive cycles; instr_valid_o high 2 cycles after FETCH entry; (instr_pc_o, instr_o) = (0x0, 0x00000013), (0x4, 0x00100093)… one per cycle.
- Backpressure: instr_ready_i = 0 for 5 cycles → at most FIFO_DEPTH (2) reads issued; instr_o stays 0x00000013; no words lost or duplicated on release.
- Redirect: redirect_i with redirect_pc_i = 0x0000000A while a read is in flight → next cycle instr_valid_o = 0; following IR_EN_o at address 0x00000008; stale word never appears.
- Simultaneous redirect + accept, and load_done_i + load_valid_i in the same cycle → redirect wins (FIFO empty next cycle); final load word written before FETCH starts.
- Reset mid-FETCH with a full FIFO → next cycle all outputs 0, state LOAD, load_ready_o = 1 after rst_i drops; with IFU_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/imem_fetch_unit.sv
// rtl/imem_fetch_unit.sv - instruction-memory requester: program load, prefetching fetch, PC redirect
// Optional macro IFU_PERF_CNT_EN adds fetch_cnt_o / stall_cnt_o performance counters.
module imem_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_valid_i,
  input  logic [31:0] load_data_i,
  output logic        load_ready_o,
  input  logic        load_done_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic [31:0] address_o,
  output logic [31:0] DATA_o,
  input  logic [31:0] DATA_i,
  output logic        IWR_EN_o,
  output logic        IR_EN_o
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {ST_LOAD, ST_FETCH} state_t;

  state_t        r_state;
  logic [31:0]   r_load_addr;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_inflight_pc;
  logic          r_inflight;
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_load;
  logic          w_fetch;
  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [CW-1:0] w_occ;
  logic [31:0]   w_redirect_pc;

  // Everything visible is gated by rst_i so outputs read zero during the reset cycle itself.
  assign w_load        = !rst_i && (r_state == ST_LOAD);
  assign w_fetch       = !rst_i && (r_state == ST_FETCH);
  assign w_valid       = !rst_i && (r_count != '0);
  assign w_pop         = w_valid && instr_ready_i;
  assign w_push        = w_fetch && r_inflight && !redirect_i;
  assign w_occ         = r_count + CW'(r_inflight) - CW'(w_pop);
  assign w_issue       = w_fetch && !redirect_i && (w_occ < DEPTH_C);
  assign w_redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;

  assign load_ready_o  = w_load;
  assign IWR_EN_o      = w_load && load_valid_i;
  assign DATA_o        = w_load ? load_data_i : '0;
  assign IR_EN_o       = w_issue;
  assign address_o     = w_load ? r_load_addr : (w_issue ? r_fetch_pc : '0);
  assign instr_valid_o = w_valid;
  assign instr_o       = w_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign instr_pc_o    = w_valid ? r_fifo_pc[r_rd_ptr] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_LOAD;
      r_load_addr   <= RESET_PC;
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
    end else if (r_state == ST_LOAD) begin
      if (load_valid_i) r_load_addr <= r_load_addr + 32'd4;
      if (load_done_i)  r_state     <= ST_FETCH;
    end else if (redirect_i) begin
      // Flush wins over push and pop; the pending response is simply not captured.
      r_fetch_pc <= w_redirect_pc;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + 32'd4;
        r_inflight_pc <= r_fetch_pc;
      end
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= DATA_i;
        r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pop)               r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_fetch && !w_valid) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o = r_fetch_cnt;
  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb/tb_imem_fetch_unit.sv - randomized self-checking bench for imem_fetch_unit
module tb_imem_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i, load_valid_i, load_done_i, redirect_i, instr_ready_i;
  logic [31:0] load_data_i, redirect_pc_i, DATA_i;
  logic        load_ready_o, instr_valid_o, IWR_EN_o, IR_EN_o;
  logic [31:0] instr_o, instr_pc_o, address_o, DATA_o;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_o, stall_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  imem_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .load_valid_i(load_valid_i), .load_data_i(load_data_i), .load_ready_o(load_ready_o),
    .load_done_i(load_done_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i), .address_o(address_o), .DATA_o(DATA_o), .DATA_i(DATA_i),
    .IWR_EN_o(IWR_EN_o), .IR_EN_o(IR_EN_o)
`ifdef IFU_PERF_CNT_EN
    , .fetch_cnt_o(fetch_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  // Instruction memory: 16 words, one-cycle read latency, garbage on DATA_i when not read.
  logic [31:0] mem [16];
  always @(posedge clk_i) begin
    if (IWR_EN_o) mem[address_o[5:2]] <= DATA_o;
    DATA_i <= IR_EN_o ? mem[address_o[5:2]] : $urandom;
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] image [16];
  logic [31:0] prog  [4];
  bit          in_fetch, exp_flush, hold_chk;
  logic [31:0] exp_load_addr, exp_issue_pc, exp_pop_pc, hold_pc, hold_instr;
  logic [31:0] m_fetch_cnt, m_stall_cnt;
  int          outstanding, issues;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference model: loaded image plus the expected sequential issue/pop PC streams.
  task automatic observe();
    bit pop, exp_issue;
    if (rst_i) begin
      check("rst_ctl", {28'd0, load_ready_o, instr_valid_o, IWR_EN_o, IR_EN_o}, 32'd0);
      check("rst_instr", instr_o, 32'd0);
      check("rst_pc", instr_pc_o, 32'd0);
      check("rst_addr", address_o, 32'd0);
      check("rst_data", DATA_o, 32'd0);
      in_fetch = 0; exp_flush = 0; hold_chk = 0; outstanding = 0;
      exp_load_addr = RPC; m_fetch_cnt = '0; m_stall_cnt = '0;
      return;
    end
    pop = instr_valid_o && instr_ready_i;
`ifdef IFU_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt_o, m_fetch_cnt);
    check("stall_cnt", stall_cnt_o, m_stall_cnt);
    if (in_fetch && pop) m_fetch_cnt++;
    if (in_fetch && !instr_valid_o) m_stall_cnt++;
`endif
    if (!in_fetch) begin
      check("ld_ready", load_ready_o, 1);
      check("ld_ren", IR_EN_o, 0);
      check("ld_valid", instr_valid_o, 0);
      check("ld_wen", IWR_EN_o, load_valid_i);
      if (load_valid_i) begin
        check("ld_addr", address_o, exp_load_addr);
        check("ld_data", DATA_o, load_data_i);
        image[exp_load_addr[5:2]] = load_data_i;
        exp_load_addr += 4;
      end
      if (load_done_i) begin
        in_fetch = 1; exp_issue_pc = RPC; exp_pop_pc = RPC;
        outstanding = 0; exp_flush = 0; hold_chk = 0;
      end
      return;
    end
    check("f_ldready", load_ready_o, 0);
    check("f_wen", IWR_EN_o, 0);
    check("f_wdata", DATA_o, 0);
    if (exp_flush) check("rd_valid0", instr_valid_o, 0);
    if (hold_chk) begin
      check("hold_valid", instr_valid_o, 1);
      check("hold_pc", instr_pc_o, hold_pc);
      check("hold_instr", instr_o, hold_instr);
    end
    exp_issue = !redirect_i && ((outstanding - (pop ? 1 : 0)) < DEPTH);
    check("issue", IR_EN_o, exp_issue);
    if (IR_EN_o) begin
      check("f_addr", address_o, exp_issue_pc);
      exp_issue_pc += 4; outstanding++; issues++;
    end
    if (instr_valid_o) begin
      check("head_pc", instr_pc_o, exp_pop_pc);
      check("head_instr", instr_o, image[exp_pop_pc[5:2]]);
    end
    if (pop) begin
      exp_pop_pc += 4; outstanding--;
    end
    check("throttle", outstanding <= DEPTH, 1);
    hold_chk = instr_valid_o && !instr_ready_i && !redirect_i;
    hold_pc = instr_pc_o; hold_instr = instr_o;
    exp_flush = redirect_i;
    if (redirect_i) begin
      exp_issue_pc = redirect_pc_i & 32'hFFFF_FFFC;
      exp_pop_pc = exp_issue_pc;
      outstanding = 0;
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    observe();
    @(posedge clk_i); #1;
  endtask

  initial begin
    prog[0] = 32'h0000_0013; prog[1] = 32'h0010_0093;
    prog[2] = 32'h0020_0113; prog[3] = 32'h0030_8193;
    rst_i = 1; load_valid_i = 1; load_data_i = $urandom; load_done_i = 0;
    redirect_i = 1; redirect_pc_i = $urandom; instr_ready_i = 1;
    in_fetch = 0; exp_flush = 0; hold_chk = 0; outstanding = 0; issues = 0;
    exp_load_addr = RPC; exp_issue_pc = RPC; exp_pop_pc = RPC;
    m_fetch_cnt = '0; m_stall_cnt = '0; hold_pc = '0; hold_instr = '0;
    @(posedge clk_i); #1;
    step(); step();
    rst_i = 0;

    // Load 16 words with gaps; final word arrives together with load_done_i.
    for (int i = 0; i < 16; ) begin
      load_valid_i  = (i < 4) || ($urandom_range(0, 3) != 0);
      load_data_i   = (i < 4) ? prog[i] : $urandom;
      redirect_i    = ($urandom_range(0, 5) == 0);
      redirect_pc_i = $urandom;
      load_done_i   = (i == 15) && load_valid_i;
      if (load_valid_i) i++;
      step();
    end
    load_valid_i = 0; load_done_i = 0; redirect_i = 0; instr_ready_i = 1;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      check("strm_valid", instr_valid_o, (c >= 2) ? 32'd1 : 32'd0);
      observe();
      @(posedge clk_i); #1;
    end

    // Backpressure from a fresh start at PC 0.
    redirect_i = 1; redirect_pc_i = 32'h0; step();
    redirect_i = 0; instr_ready_i = 0; issues = 0;
    for (int c = 0; c < 6; c++) step();
    @(negedge clk_i);
    check("bp_issues", issues, DEPTH);
    check("bp_instr", instr_o, prog[0]);
    check("bp_pc", instr_pc_o, 32'h0);
    observe();
    @(posedge clk_i); #1;
    instr_ready_i = 1;
    for (int c = 0; c < 4; c++) step();

    // Redirect with a read in flight and a simultaneous accept.
    redirect_i = 1; redirect_pc_i = 32'h0000_000A; step();
    redirect_i = 0;
    @(negedge clk_i);
    check("rd_next_valid", instr_valid_o, 0);
    check("rd_next_addr", address_o, 32'h8);
    observe();
    @(posedge clk_i); #1;
    for (int c = 0; c < 6; c++) step();

    for (int c = 0; c < 400; c++) begin
      instr_ready_i = ($urandom_range(0, 3) != 0);
      redirect_i    = ($urandom_range(0, 15) == 0);
      redirect_pc_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step();
    end

    // Fill the FIFO, then reset mid-fetch.
    redirect_i = 0; instr_ready_i = 0;
    for (int c = 0; c < 4; c++) step();
    @(negedge clk_i);
    check("full_valid", instr_valid_o, 1);
    observe();
    @(posedge clk_i); #1;
    rst_i = 1; step();
    rst_i = 0;
    @(negedge clk_i);
    check("post_rst_ready", load_ready_o, 1);
    check("post_rst_valid", instr_valid_o, 0);
    check("post_rst_ren", IR_EN_o, 0);
`ifdef IFU_PERF_CNT_EN
    check("post_rst_fcnt", fetch_cnt_o, 32'd0);
    check("post_rst_scnt", stall_cnt_o, 32'd0);
`endif
    observe();
    @(posedge clk_i); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
